// File: rtl/ysyx_25010030_icache_assoc_if.sv
// IFU fetch handshake, fence.i pulse and AXI4 read channels of the instruction cache.
interface ysyx_25010030_icache_assoc_if;
    logic        is_fencei;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic [3:0]  axi_arid;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arready;
    logic        axi_rvalid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic [3:0]  axi_rid;
    logic        axi_rlast;
    logic        axi_rready;

    // Cache side
    modport slave (
        input  is_fencei, req_valid, req_addr,
        input  axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rid, axi_rlast,
        output req_ready, resp_valid, resp_inst, resp_err,
        output axi_araddr, axi_arvalid, axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_rready
    );

    // IFU / AXI slave side
    modport master (
        output is_fencei, req_valid, req_addr,
        output axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rid, axi_rlast,
        input  req_ready, resp_valid, resp_inst, resp_err,
        input  axi_araddr, axi_arvalid, axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_rready
    );
endinterface

// File: rtl/ysyx_25010030_icache_assoc.sv
// N-way set-associative instruction cache with burst refill, uncached window,
// fence.i invalidation and AXI error reporting.
module ysyx_25010030_icache_assoc #(
    parameter int unsigned CACHE_SIZE = 256,
    parameter int unsigned BLOCK_SIZE = 16,
    parameter int unsigned WAYS       = 2,
    parameter logic [31:0] UNC_BASE   = 32'h1000_0000,
    parameter logic [31:0] UNC_END    = 32'h1FFF_FFFF
) (
    input logic clk,
    input logic reset,
    ysyx_25010030_icache_assoc_if.slave bus
);
    localparam int unsigned SETS  = CACHE_SIZE / (BLOCK_SIZE * WAYS);
    localparam int unsigned BEATS = BLOCK_SIZE / 4;
    localparam int unsigned OFF   = $clog2(BLOCK_SIZE);
    localparam int unsigned IDX   = $clog2(SETS);
    localparam int unsigned TAG   = 32 - IDX - OFF;
    localparam int unsigned SW    = (SETS > 1) ? IDX : 1;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

    function automatic logic [SW-1:0] set_of(input logic [31:0] a);
        return SW'((a >> OFF) & 32'(SETS - 1));
    endfunction
    function automatic logic [TAG-1:0] tag_of(input logic [31:0] a);
        return TAG'(a >> (OFF + IDX));
    endfunction
    function automatic logic [BW-1:0] word_of(input logic [31:0] a);
        return BW'((a >> 2) & 32'(BEATS - 1));
    endfunction

    logic [WAYS-1:0] valid_q [SETS];
    logic [WW-1:0]   ptr_q   [SETS];
    logic [TAG-1:0]  tag_q   [SETS][WAYS];
    logic [31:0]     data_q  [SETS][WAYS][BEATS];
    logic [31:0]     line_q  [BEATS];

    state_t      state_q;
    logic [31:0] addr_q;
    logic        unc_q;
    logic [BW-1:0] cnt_q;
    logic        line_err_q;
    logic        fence_seen_q;
    logic [31:0] word_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_inst_q;
    logic        resp_err_q;
    logic [31:0] araddr_q;
    logic        arvalid_q;
    logic [7:0]  arlen_q;
    logic [2:0]  arsize_q;
    logic [1:0]  arburst_q;
    logic        rready_q;

    logic [SW-1:0]  req_set_c;
    logic [TAG-1:0] req_tag_c;
    logic [BW-1:0]  req_word_c;
    logic           unc_c;
    logic           hit_c;
    logic [WW-1:0]  hit_way_c;
    logic [SW-1:0]  miss_set_c;
    logic [TAG-1:0] miss_tag_c;
    logic [BW-1:0]  miss_word_c;
    logic [WW-1:0]  victim_c;
    logic           found_c;
    logic           install_c;
    logic           beat_word_c;
    logic           unused_c;

    assign req_set_c   = set_of(bus.req_addr);
    assign req_tag_c   = tag_of(bus.req_addr);
    assign req_word_c  = word_of(bus.req_addr);
    assign unc_c       = (bus.req_addr >= UNC_BASE) && (bus.req_addr <= UNC_END);
    assign miss_set_c  = set_of(addr_q);
    assign miss_tag_c  = tag_of(addr_q);
    assign miss_word_c = word_of(addr_q);
    assign beat_word_c = unc_q || (cnt_q == miss_word_c);
    assign install_c   = (state_q == RESP) && !unc_q && !line_err_q && !fence_seen_q && !bus.is_fencei;
    assign unused_c    = ^bus.axi_rid;

    assign bus.req_ready   = req_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_inst   = resp_inst_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.axi_araddr  = araddr_q;
    assign bus.axi_arvalid = arvalid_q;
    assign bus.axi_arid    = 4'd0;
    assign bus.axi_arlen   = arlen_q;
    assign bus.axi_arsize  = arsize_q;
    assign bus.axi_arburst = arburst_q;
    assign bus.axi_rready  = rready_q;

    // Parallel tag compare across the ways of the requested set; a fence forces a miss.
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_set_c][WW'(w)] && (tag_q[req_set_c][WW'(w)] == req_tag_c)
                && !bus.is_fencei && !unc_c) begin
                hit_c     = 1'b1;
                hit_way_c = WW'(w);
            end
        end
    end

    // Victim: lowest-numbered invalid way, else the set's round-robin pointer.
    always_comb begin
        victim_c = ptr_q[miss_set_c];
        found_c  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_c && !valid_q[miss_set_c][WW'(w)]) begin
                victim_c = WW'(w);
                found_c  = 1'b1;
            end
        end
    end

    // Valid bits and victim pointers; fence wins over a same-cycle install.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[SW'(s)] <= '0;
                ptr_q[SW'(s)]   <= '0;
            end
        end else if (bus.is_fencei) begin
            for (int s = 0; s < SETS; s++) valid_q[SW'(s)] <= '0;
        end else if (install_c) begin
            valid_q[miss_set_c][victim_c] <= 1'b1;
            ptr_q[miss_set_c] <= WW'((32'(ptr_q[miss_set_c]) + 32'd1) % 32'(WAYS));
        end
    end

    // Tag/data arrays and refill line buffer; contents are qualified by valid bits.
    always_ff @(posedge clk) begin
        if (state_q == R && bus.axi_rvalid) line_q[cnt_q] <= bus.axi_rdata;
        if (install_c) begin
            tag_q[miss_set_c][victim_c] <= miss_tag_c;
            for (int b = 0; b < BEATS; b++) data_q[miss_set_c][victim_c][BW'(b)] <= line_q[BW'(b)];
        end
    end

    // Lookup / refill FSM with registered IFU and AXI outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            unc_q        <= 1'b0;
            cnt_q        <= '0;
            line_err_q   <= 1'b0;
            fence_seen_q <= 1'b0;
            word_q       <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= '0;
            resp_err_q   <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arburst_q    <= '0;
            rready_q     <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        if (hit_c) begin
                            resp_valid_q <= 1'b1;
                            resp_inst_q  <= data_q[req_set_c][hit_way_c][req_word_c];
                            resp_err_q   <= 1'b0;
                        end else begin
                            state_q      <= AR;
                            req_ready_q  <= 1'b0;
                            addr_q       <= {bus.req_addr[31:2], 2'b00};
                            unc_q        <= unc_c;
                            cnt_q        <= '0;
                            line_err_q   <= 1'b0;
                            fence_seen_q <= 1'b0;
                            arvalid_q    <= 1'b1;
                            arsize_q     <= 3'b010;
                            if (unc_c) begin
                                araddr_q  <= {bus.req_addr[31:2], 2'b00};
                                arlen_q   <= 8'd0;
                                arburst_q <= 2'b00;
                            end else begin
                                araddr_q  <= bus.req_addr & ~32'(BLOCK_SIZE - 1);
                                arlen_q   <= 8'(BEATS - 1);
                                arburst_q <= 2'b01;
                            end
                        end
                    end
                end
                AR: begin
                    if (bus.is_fencei) fence_seen_q <= 1'b1;
                    if (bus.axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= R;
                    end
                end
                R: begin
                    if (bus.is_fencei) fence_seen_q <= 1'b1;
                    if (bus.axi_rvalid) begin
                        cnt_q      <= cnt_q + BW'(1);
                        line_err_q <= line_err_q | (bus.axi_rresp != 2'b00);
                        if (beat_word_c) word_q <= bus.axi_rdata;
                        if (bus.axi_rlast) begin
                            rready_q     <= 1'b0;
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_inst_q  <= beat_word_c ? bus.axi_rdata : word_q;
                            resp_err_q   <= line_err_q | (bus.axi_rresp != 2'b00);
                        end
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25010030_icache_assoc.sv
// Self-checking bench: directed scenarios plus randomized fetches against a line-level cache model.
module tb_ysyx_25010030_icache_assoc;
    localparam int unsigned CACHE_SIZE = 256;
    localparam int unsigned BLOCK_SIZE = 16;
    localparam int unsigned WAYS       = 2;
    localparam int unsigned SETS       = CACHE_SIZE / (BLOCK_SIZE * WAYS);
    localparam int unsigned BEATS      = BLOCK_SIZE / 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ysyx_25010030_icache_assoc_if bus();

    ysyx_25010030_icache_assoc #(
        .CACHE_SIZE(CACHE_SIZE), .BLOCK_SIZE(BLOCK_SIZE), .WAYS(WAYS),
        .UNC_BASE(32'h1000_0000), .UNC_END(32'h1FFF_FFFF)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: which line address each way of each set holds, plus round-robin pointers.
    bit          m_valid [SETS][WAYS];
    logic [31:0] m_line  [SETS][WAYS];
    int          m_ptr   [SETS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit is_unc(input logic [31:0] a);
        return (a >= 32'h1000_0000) && (a <= 32'h1FFF_FFFF);
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'(BLOCK_SIZE - 1);
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a / BLOCK_SIZE) % SETS);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        bit h = 1'b0;
        if (is_unc(a)) return 1'b0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[set_of(a)][w] && m_line[set_of(a)][w] == line_of(a)) h = 1'b1;
        return h;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
    endtask

    task automatic model_install(input logic [31:0] a);
        int s, v;
        s = set_of(a);
        v = -1;
        for (int w = 0; w < WAYS; w++) if (v < 0 && !m_valid[s][w]) v = w;
        if (v < 0) v = m_ptr[s];
        m_valid[s][v] = 1'b1;
        m_line[s][v]  = line_of(a);
        m_ptr[s]      = (m_ptr[s] + 1) % WAYS;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    // One fetch: issue request, act as AXI slave on a miss, check response against the model.
    task automatic fetch(input logic [31:0] a, input int err_beat, input int fence_beat,
                         input bit fence_req, input int ar_delay);
        bit hit, unc, bad, fenced;
        int nb;
        logic [31:0] line, exp_inst;
        wait_ready();
        unc = is_unc(a);
        if (fence_req) model_clear();
        hit = model_hit(a);
        exp_inst = mem_word(a);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.is_fencei = fence_req;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.is_fencei = 1'b0;
        if (hit) begin
            check("hit_valid", 32'(bus.resp_valid), 32'd1);
            check("hit_inst", bus.resp_inst, exp_inst);
            check("hit_err", 32'(bus.resp_err), 32'd0);
            check("hit_no_ar", 32'(bus.axi_arvalid), 32'd0);
            return;
        end
        nb   = unc ? 1 : int'(BEATS);
        line = unc ? (a & 32'hFFFF_FFFC) : line_of(a);
        check("miss_no_resp", 32'(bus.resp_valid), 32'd0);
        check("arvalid", 32'(bus.axi_arvalid), 32'd1);
        check("araddr", bus.axi_araddr, line);
        check("arlen", 32'(bus.axi_arlen), 32'(nb - 1));
        check("arburst", 32'(bus.axi_arburst), unc ? 32'd0 : 32'd1);
        check("arsize", 32'(bus.axi_arsize), 32'd2);
        check("arid", 32'(bus.axi_arid), 32'd0);
        for (int d = 0; d < ar_delay; d++) begin
            @(negedge clk);
            check("ar_hold", 32'(bus.axi_arvalid), 32'd1);
            check("araddr_hold", bus.axi_araddr, line);
        end
        bus.axi_arready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.axi_arready = 1'b0;
        check("arvalid_drop", 32'(bus.axi_arvalid), 32'd0);
        check("rready", 32'(bus.axi_rready), 32'd1);
        bad = 1'b0;
        fenced = 1'b0;
        for (int k = 0; k < nb; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.axi_rvalid = 1'b0;
                @(negedge clk);
            end
            bus.axi_rvalid = 1'b1;
            bus.axi_rdata  = mem_word(line + 32'(4 * k));
            bus.axi_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            bus.axi_rlast  = (k == nb - 1);
            bus.axi_rid    = 4'($urandom);
            bus.is_fencei  = (k == fence_beat);
            if (k == err_beat) bad = 1'b1;
            if (k == fence_beat) fenced = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.is_fencei = 1'b0;
        end
        bus.axi_rvalid = 1'b0;
        bus.axi_rlast  = 1'b0;
        bus.axi_rresp  = 2'b00;
        if (fenced) model_clear();
        check("refill_valid", 32'(bus.resp_valid), 32'd1);
        check("refill_inst", bus.resp_inst, exp_inst);
        check("refill_err", 32'(bus.resp_err), 32'(bad));
        check("rready_drop", 32'(bus.axi_rready), 32'd0);
        if (!unc && !bad && !fenced) model_install(a);
        @(negedge clk);
        check("resp_pulse", 32'(bus.resp_valid), 32'd0);
        check("ready_again", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b2b [4];
        reset = 1'b1;
        bus.is_fencei = 1'b0; bus.req_valid = 1'b0; bus.req_addr = '0;
        bus.axi_arready = 1'b0; bus.axi_rvalid = 1'b0; bus.axi_rdata = '0;
        bus.axi_rresp = 2'b00; bus.axi_rid = '0; bus.axi_rlast = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_inst", bus.resp_inst, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_arvalid", 32'(bus.axi_arvalid), 32'd0);
        check("rst_araddr", bus.axi_araddr, 32'd0);
        check("rst_arlen", 32'(bus.axi_arlen), 32'd0);
        check("rst_rready", 32'(bus.axi_rready), 32'd0);
        reset = 1'b0;

        // Cold miss then hit
        fetch(32'h8000_0004, -1, -1, 1'b0, 0);
        fetch(32'h8000_0004, -1, -1, 1'b0, 0);

        // Three lines into one set, round-robin eviction
        fetch(32'h8000_0010, -1, -1, 1'b0, 1);
        fetch(32'h8000_0090, -1, -1, 1'b0, 0);
        fetch(32'h8000_0110, -1, -1, 1'b0, 2);
        fetch(32'h8000_0094, -1, -1, 1'b0, 0);
        fetch(32'h8000_0018, -1, -1, 1'b0, 0);

        // Back-to-back hits, one per cycle
        b2b[0] = 32'h8000_0018; b2b[1] = 32'h8000_0110;
        b2b[2] = 32'h8000_0008; b2b[3] = 32'h8000_011C;
        wait_ready();
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = b2b[i];
            @(posedge clk);
            @(negedge clk);
            check("b2b_valid", 32'(bus.resp_valid), 32'(model_hit(b2b[i])));
            check("b2b_inst", bus.resp_inst, mem_word(b2b[i]));
        end
        bus.req_valid = 1'b0;

        // Uncached window: two independent single-beat reads
        fetch(32'h1000_0008, -1, -1, 1'b0, 0);
        fetch(32'h1000_0008, -1, -1, 1'b0, 1);

        // Error on beat 2: reported, line not installed
        fetch(32'h8000_0204, 2, -1, 1'b0, 0);
        fetch(32'h8000_0204, -1, -1, 1'b0, 0);

        // Fence during beat 1 of a refill, then fence with a hitting request
        fetch(32'h8000_0308, -1, 1, 1'b0, 0);
        fetch(32'h8000_0308, -1, -1, 1'b0, 0);
        fetch(32'h8000_0308, -1, -1, 1'b1, 0);

        // Randomized mix of cached/uncached fetches, errors and fences
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0)
                a = 32'h1000_0000 + 32'($urandom_range(0, 63) * 4);
            else
                a = 32'h8000_0000 + 32'($urandom_range(0, 3) * 128)
                    + 32'($urandom_range(0, 7) * 16) + 32'($urandom_range(0, 3) * 4);
            fetch(a,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1,
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1,
                  ($urandom_range(0, 15) == 0),
                  int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a burst
        fetch(32'h8000_0044, -1, -1, 1'b0, 0);
        a = 32'h8000_00C0;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid   = 1'b0;
        bus.axi_arready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.axi_arready = 1'b0;
        bus.axi_rvalid  = 1'b1;
        bus.axi_rdata   = mem_word(a);
        @(posedge clk);
        @(negedge clk);
        check("midr_rready", 32'(bus.axi_rready), 32'd1);
        reset = 1'b1;
        bus.axi_rvalid = 1'b0;
        #1;
        check("rst_mid_arvalid", 32'(bus.axi_arvalid), 32'd0);
        check("rst_mid_rready", 32'(bus.axi_rready), 32'd0);
        check("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        fetch(32'h8000_0044, -1, -1, 1'b0, 0);
        fetch(32'h8000_0044, -1, -1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
